hilo_mdu: RTL and testbench
===========================

HILO_MDU -- requirements
Module: hilo_mdu

Interface
REQ-001 Parameter: WIDTH, 32, operand and HI/LO register width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to launch the operation in op; sampled only in IDLE.
REQ-005 op  input  2  operation select: 00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO.
REQ-006 a  input  WIDTH  rs operand (multiplicand / dividend / MTHI, MTLO source).
REQ-007 b  input  WIDTH  rt operand (multiplier / divisor); ignored for MTHI/MTLO.
REQ-008 busy  output  1  high while an iterative operation is in progress.
REQ-009 done  output  1  single-cycle pulse: the operation has committed to HI/LO.
REQ-010 hi  output  WIDTH  architectural HI register, read by MFHI via the register-file write-data mux.
REQ-011 lo  output  WIDTH  architectural LO register, read by MFLO.

Function
REQ-012 FSM states: IDLE, BUSY, DONE; exactly one active at a time.
REQ-013 IDLE, start=0: remain in IDLE; busy=0, done=0.
REQ-014 IDLE, start=1, op=MULTU: latch a and b, clear the iteration counter, enter BUSY.
REQ-015 IDLE, start=1, op=DIVU, b!=0: latch a and b, clear the iteration counter, enter BUSY.
REQ-016 IDLE, start=1, op=DIVU, b=0: on the same edge write hi=a and lo=all-ones, enter DONE.
REQ-017 IDLE, start=1, op=MTHI: on the same edge write hi=a with lo unchanged, enter DONE.
REQ-018 IDLE, start=1, op=MTLO: on the same edge write lo=a with hi unchanged, enter DONE.
REQ-019 BUSY performs exactly WIDTH iterations, one per clock.
REQ-020 MULTU uses radix-2 shift-add and produces an unsigned 2*WIDTH-bit product.
REQ-021 DIVU uses radix-2 restoring division and produces an unsigned quotient and remainder.
REQ-022 On the edge completing iteration WIDTH: write hi/lo, enter DONE.
REQ-023 MULTU results: hi = product[2*WIDTH-1:WIDTH], lo = product[WIDTH-1:0].
REQ-024 DIVU results: hi = remainder, lo = quotient.
REQ-025 MULTU/DIVU latency: with the accepting edge as E0, results are written at edge E32 (WIDTH=32), done is high for the cycle after E32, and the FSM returns to IDLE at E33.
REQ-026 busy is high from after E0 through the cycle ending at E32, and low in DONE and IDLE.
REQ-027 DONE lasts exactly one cycle, then the FSM returns to IDLE unconditionally.
REQ-028 start during BUSY or DONE is ignored: no queuing, and operands are not re-latched.
REQ-029 A new start is accepted no earlier than the cycle after DONE.
REQ-030 hi and lo keep their previous values throughout BUSY; intermediate values are held in internal working registers only.
REQ-031 Changes on a, b or op after the accepting edge have no effect on the result.
REQ-032 The iteration counter is WIDTH-aware with width clog2(WIDTH)+1, and it never wraps during an operation.
REQ-033 No overflow condition exists: a full 2*WIDTH-bit product is always retained.
REQ-034 hi, lo, busy and done are driven directly from registers, with no combinational path from the inputs.

Reset
REQ-035 rst_n=0 asynchronously forces IDLE, busy=0, done=0, hi=0, lo=0, and clears the working registers and counter.
REQ-036 Reset asserted mid-BUSY aborts the operation; hi and lo read 0, and no done pulse follows.
REQ-037 While rst_n=0, start is ignored; the first start accepted is at the first rising edge with rst_n=1.

Verification
REQ-038 MULTU, a=FFFFFFFF, b=FFFFFFFF -> busy high for 32 cycles; done in the 33rd cycle after E0; hi=FFFFFFFE, lo=00000001.
REQ-039 DIVU, a=100, b=7 -> after 32 busy cycles, done with lo=0000000E, hi=00000002.
REQ-040 DIVU, a=12345678, b=0 -> busy never asserts; done in the cycle after E0; hi=12345678, lo=FFFFFFFF.
REQ-041 MTHI a=DEADBEEF, then MTLO a=CAFEF00D -> each gives a one-cycle done; final hi=DEADBEEF, lo=CAFEF00D.
REQ-042 MULTU 3*5 started, then start=1 with op=DIVU at cycle 10 of BUSY -> the second start is ignored; result hi=0, lo=0000000F at E32.
REQ-043 MULTU started with hi/lo holding prior values, then rst_n pulsed low at cycle 16 of BUSY -> immediate IDLE; hi=lo=0, busy=0, no done; a fresh MULTU 2*3 then yields lo=6.

Source files
------------

// File: rtl/hilo_mdu.sv
// HI/LO multiply-divide unit: iterative radix-2 MULTU/DIVU plus single-cycle MTHI/MTLO.
// One result bit per clock over WIDTH cycles; HI/LO only change when an operation commits.
module hilo_mdu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  localparam logic [1:0] OpMultu = 2'b00;
  localparam logic [1:0] OpDivu  = 2'b01;
  localparam logic [1:0] OpMthi  = 2'b10;
  localparam logic [1:0] OpMtlo  = 2'b11;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   work_q, work_d, work_step;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 is_div_q, is_div_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [WIDTH:0]       mul_sum, div_rem, div_diff;

  // work_q holds {upper, lower}: product/multiplier for MULTU, remainder/quotient for DIVU.
  always_comb begin
    mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    div_rem  = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_diff = div_rem - {1'b0, opnd_q};
    if (is_div_q) begin
      if (!div_diff[WIDTH]) begin
        work_step = {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
      end else begin
        work_step = {div_rem[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      work_step = {mul_sum, work_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StDone;
          unique case (op)
            OpMultu: begin
              is_div_d = 1'b0;
              opnd_d   = a;
              work_d   = {{WIDTH{1'b0}}, b};
              cnt_d    = '0;
              state_d  = StBusy;
            end
            OpDivu: begin
              if (b == '0) begin
                hi_d = a;
                lo_d = '1;
              end else begin
                is_div_d = 1'b1;
                opnd_d   = b;
                work_d   = {{WIDTH{1'b0}}, a};
                cnt_d    = '0;
                state_d  = StBusy;
              end
            end
            OpMthi:  hi_d = a;
            OpMtlo:  lo_d = a;
            default: ;
          endcase
        end
      end
      StBusy: begin
        work_d = work_step;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          hi_d    = work_step[2*WIDTH-1:WIDTH];
          lo_d    = work_step[WIDTH-1:0];
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StBusy);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      work_q   <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Bench for hilo_mdu: expected HI/LO pairs are queued at launch and checked on the done pulse.
module tb_hilo_mdu;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] sb_q[$];
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  hilo_mdu #(.WIDTH(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour, updates the bench's own HI/LO model.
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    unique case (o)
      2'b00: begin
        p    = 64'(x) * 64'(y);
        hi_m = p[63:32];
        lo_m = p[31:0];
      end
      2'b01: begin
        if (y == 0) begin
          hi_m = x;
          lo_m = '1;
        end else begin
          hi_m = x % y;
          lo_m = x / y;
        end
      end
      2'b10:   hi_m = x;
      default: lo_m = x;
    endcase
  endtask

  // Launch one op; inject_at >= 1 raises a stray DIVU start at that busy cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int exp_busy, input int inject_at);
    logic [63:0] exp;
    logic [31:0] hi_prev;
    int          nbusy;
    bit          seen;
    hi_prev = hi;
    model(o, x, y);
    sb_q.push_back({hi_m, lo_m});
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    nbusy = 0;
    seen  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) begin
        seen = 1;
      end else begin
        if (busy) nbusy++;
        if (nbusy == 16 && busy) check({tag, "_hi_hold"}, 64'(hi), 64'(hi_prev));
        if (inject_at > 0 && nbusy == inject_at) begin
          start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_busy_cycles"}, 64'(nbusy), 64'(exp_busy));
    if (seen) begin
      exp = sb_q.pop_front();
      check({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
      check({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
      check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    end else begin
      void'(sb_q.pop_front());
    end
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'({busy, done}), 64'd0);
  endtask

  initial begin
    int ndone;
    logic [31:0] x, y;
    rst_n = 1'b0;
    start = 1'b1; op = 2'b10; a = 32'h5555_5555; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {hi, lo}, 64'd0);
    check("rst_flags", 64'({busy, done}), 64'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 0);
    check("mul_ff_value", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("div_100_7", 2'b01, 32'd100, 32'd7, 32, 0);
    check("div_value", {hi, lo}, {32'h2, 32'hE});
    run_op("div_by0", 2'b01, 32'h1234_5678, 32'd0, 0, 0);
    check("div0_value", {hi, lo}, {32'h1234_5678, 32'hFFFF_FFFF});
    run_op("mthi", 2'b10, 32'hDEAD_BEEF, 32'h0, 0, 0);
    run_op("mtlo", 2'b11, 32'hCAFE_F00D, 32'h0, 0, 0);
    check("mt_value", {hi, lo}, {32'hDEAD_BEEF, 32'hCAFE_F00D});
    run_op("mul_inject", 2'b00, 32'd3, 32'd5, 32, 10);
    check("inject_value", {hi, lo}, 64'h0000_0000_0000_000F);

    for (int k = 0; k < 4; k++) begin
      x = $urandom;
      y = $urandom_range(1, 32'hFFFF);
      run_op("rnd_mul", 2'b00, x, y, 32, 0);
      run_op("rnd_div", 2'b01, x, y, 32, 0);
    end
    run_op("div_small", 2'b01, 32'd5, 32'hFFFF_FFFF, 32, 0);

    // Abort mid-operation with a reset pulse.
    op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("abort_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_flags", 64'({busy, done}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    repeat (36) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    hi_m = '0;
    lo_m = '0;
    run_op("mul_after_rst", 2'b00, 32'd2, 32'd3, 32, 0);
    check("after_rst_lo", 64'(lo), 64'd6);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got none expected finish");
    $fatal(1);
  end

endmodule
